// File: rtl/mul8_seq_pkg.sv
// Shared encodings for the multi-cycle ALU units and their sequencer.
package mul8_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addern.sv
// N-bit ripple adder with carry in/out, shared by the ALU datapath.
module addern #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/mul8_seq.sv
// Sequential shift-and-add unsigned multiplier, one partial product per clock.
module mul8_seq
    import mul8_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state, state_next;

    logic [WIDTH-1:0] acc, q, m;
    logic [WIDTH-1:0] addend, sum;
    logic [CW-1:0]    cnt;
    logic             cout;
    logic             last;

    assign addend = q[0] ? m : '0;
    assign last   = (cnt == LAST);

    addern #(.WIDTH(WIDTH)) u_add (
        .a    (acc),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // cnt holds on the final step so it never wraps past WIDTH-1
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            q       <= '0;
            m       <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m   <= a;
                        q   <= b;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    acc <= {cout, sum[WIDTH-1:1]};
                    q   <= {sum[0], q[WIDTH-1:1]};
                    if (last)
                        product <= {cout, sum[WIDTH-1:1], sum[0], q[WIDTH-1:1]};
                    else
                        cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mul8_seq.sv
// Bench for mul8_seq: 8-bit directed/random runs and a 4-bit exhaustive sweep.
module tb_mul8_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8, start8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    logic        rst4, start4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  product4;

    mul8_seq #(.WIDTH(8)) u8 (
        .clk     (clk),
        .rst     (rst8),
        .start   (start8),
        .a       (a8),
        .b       (b8),
        .busy    (busy8),
        .done    (done8),
        .product (product8)
    );

    mul8_seq #(.WIDTH(4)) u4 (
        .clk     (clk),
        .rst     (rst4),
        .start   (start4),
        .a       (a4),
        .b       (b4),
        .busy    (busy4),
        .done    (done4),
        .product (product4)
    );

    int compared = 0;
    int mismatched = 0;
    logic armed = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Timeline model: t counts cycles since an accepted start (0 = idle)
    typedef struct {
        int          t;
        logic [15:0] ma;
        logic [15:0] mb;
        logic [15:0] prod;
    } model_t;

    function automatic model_t step(model_t cur, int w, logic r, logic s,
                                    logic [15:0] x, logic [15:0] y);
        model_t n;
        n = cur;
        if (r) begin
            n.t    = 0;
            n.prod = '0;
        end else if (cur.t == 0) begin
            if (s) begin
                n.t  = 1;
                n.ma = x;
                n.mb = y;
            end
        end else if (cur.t == w + 1) begin
            n.t = 0;
        end else begin
            n.t = cur.t + 1;
            if (n.t == w + 1) n.prod = cur.ma * cur.mb;
        end
        return n;
    endfunction

    model_t m8 = '{t: 0, ma: '0, mb: '0, prod: '0};
    model_t m4 = '{t: 0, ma: '0, mb: '0, prod: '0};

    always @(posedge clk) begin
        m8 = step(m8, 8, rst8, start8, {8'h0, a8}, {8'h0, b8});
        m4 = step(m4, 4, rst4, start4, {12'h0, a4}, {12'h0, b4});
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("busy8", {31'b0, busy8}, {31'b0, m8.t != 0});
            chk("done8", {31'b0, done8}, {31'b0, m8.t == 9});
            chk("product8", {16'h0, product8}, {16'h0, m8.prod});
            chk("busy4", {31'b0, busy4}, {31'b0, m4.t != 0});
            chk("done4", {31'b0, done4}, {31'b0, m4.t == 5});
            chk("product4", {24'h0, product4}, {16'h0, m4.prod});
        end
    end

    // Returns the cycle index (start cycle = 0) at which done was seen
    task automatic run8(input logic [7:0] x, input logic [7:0] y, output int lat);
        @(negedge clk);
        a8 = x; b8 = y; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        lat = 1;
        while (!done8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run4(input logic [3:0] x, input logic [3:0] y, output int lat);
        @(negedge clk);
        a4 = x; b4 = y; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        a4 = 4'($urandom);
        b4 = 4'($urandom);
        lat = 1;
        while (!done4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic seq8();
        int lat, k;
        logic [7:0] x, y;

        run8(8'h0F, 8'h11, lat);
        chk("t1_latency", lat, 9);
        chk("t1_product", {16'h0, product8}, 32'h00FF);

        run8(8'hFF, 8'hFF, lat);
        chk("t2_ffxff", {16'h0, product8}, 32'hFE01);
        run8(8'h00, 8'h5A, lat);
        chk("t2_zero", {16'h0, product8}, 32'h0000);
        run8(8'h80, 8'h02, lat);
        chk("t2_msb", {16'h0, product8}, 32'h0100);

        @(negedge clk);
        a8 = 8'h21; b8 = 8'h03; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (5) @(negedge clk);
        chk("t3_done_c9", {31'b0, done8}, 32'd1);
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        chk("t3_idle_c10", {31'b0, busy8}, 32'd0);
        chk("t3_product", {16'h0, product8}, 32'h0063);

        @(negedge clk);
        a8 = 8'h05; b8 = 8'h07; start8 = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!done8 && k < 20);
        chk("t3_held_first", k, 9);
        k = 0;
        do begin @(negedge clk); k++; end while (!done8 && k < 20);
        chk("t3_held_period", k, 10);
        start8 = 1'b0;
        chk("t3_held_product", {16'h0, product8}, 32'h0023);

        @(negedge clk);
        a8 = 8'h33; b8 = 8'h44; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0; start8 = 1'b0;
        chk("t4_busy", {31'b0, busy8}, 32'd0);
        chk("t4_product", {16'h0, product8}, 32'h0000);
        k = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) k++;
        end
        chk("t4_no_done", k, 0);
        run8(8'h0C, 8'h0D, lat);
        chk("t4_restart", {16'h0, product8}, 32'h009C);

        run8(8'h12, 8'h34, lat);
        chk("t5_first", {16'h0, product8}, 32'h03A8);
        @(negedge clk);
        a8 = 8'h02; b8 = 8'h03; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        k = 1;
        while (!done8 && k < 20) begin
            chk("t5_hold", {16'h0, product8}, 32'h03A8);
            @(negedge clk);
            k++;
        end
        chk("t5_latency", k, 9);
        chk("t5_second", {16'h0, product8}, 32'h0006);

        for (int i = 0; i < 181; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            run8(x, y, lat);
            chk("rand_latency", lat, 9);
            chk("rand_product", {16'h0, product8}, {16'h0, {8'h0, x} * {8'h0, y}});
        end
    endtask

    task automatic seq4();
        int lat;
        logic [3:0] x, y;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                x = 4'(i);
                y = 4'(j);
                run4(x, y, lat);
                chk("w4_latency", lat, 5);
                chk("w4_product", {24'h0, product4}, {24'h0, {4'h0, x} * {4'h0, y}});
            end
        end
    endtask

    initial begin
        rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
        rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0;
        repeat (2) @(negedge clk);
        rst8 = 1'b0;
        rst4 = 1'b0;
        armed = 1'b1;
        chk("rst_busy", {31'b0, busy8}, 32'd0);
        chk("rst_done", {31'b0, done8}, 32'd0);
        chk("rst_product", {16'h0, product8}, 32'h0);
        fork
            seq8();
            seq4();
        join
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul8_seq.md
Name: mul8_seq

Overview:
Sequential shift-and-add unsigned multiplier. It consumes the sum and carry-out of one `addern` instance, one partial product per clock. It sits downstream of the ripple adder in the ALU datapath and gives the CPU a multi-cycle MUL without a combinational array. A simple start/busy/done handshake connects it to the control sequencer.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH; must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  multiplicand; captured on accepted start.
- b  input  WIDTH  multiplier; captured on accepted start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; product valid and updated.
- product  output  2*WIDTH  registered result; holds until next completion.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, product=0, internal acc/q/m/cnt=0.
- States:
  - IDLE: busy=0. On start=1, load m<=a, q<=b, acc<=0, cnt<=0, then go to RUN. On start=0, stay.
  - RUN: busy=1, one step per cycle. When cnt==WIDTH-1 at the edge, load product and go to DONE.
  - DONE: busy=1, done=1 for exactly this cycle, then go to IDLE unconditionally.
- Step datapath:
  - Adder inputs: addern a=acc, b=(q[0] ? m : 0), cin=0, giving sum[WIDTH-1:0] and cout.
  - Update: acc<={cout, sum[WIDTH-1:1]}; q<={sum[0], q[WIDTH-1:1]}; cnt<=cnt+1.
  - The final step writes product<={cout, sum[WIDTH-1:1], sum[0], q[WIDTH-1:1]}. This is the same value acc/q take at that edge.
- Latency: start high in cycle 0 (IDLE) gives:
  - RUN in cycles 1..WIDTH;
  - DONE/done=1 in cycle WIDTH+1;
  - IDLE in cycle WIDTH+2.
  - Throughput is one multiply per WIDTH+2 cycles.
- start in RUN or DONE is ignored, with no queuing. A start held high continuously is re-accepted in the first IDLE cycle.
- a and b are don't-care except in the accepting cycle; later changes do not affect the result.
- product changes only at the DONE-entry edge (or reset). It is stable in IDLE and throughout a following RUN.
- Arithmetic: unsigned; the product never overflows 2*WIDTH bits. cout of every step must be kept; dropping it corrupts results with high operands (e.g. 0xFF*0xFF).
- cnt width is $clog2(WIDTH). It counts 0..WIDTH-1 with no wrap beyond.
- rst mid-operation: returns to IDLE next edge, clears product to 0, no done pulse. rst wins over start in the same cycle.

Decomposition:
- Shared constants file: state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2 (2'd3 illegal; go to IDLE). The sequencer and other multi-cycle ALU units include this file.
- Sub-module: reuse existing `addern #(WIDTH)` for the add. No new adder.
- Remaining logic (state register, cnt, acc/q/m shift registers, product register) stays flat in mul8_seq.

Test Plan:
1. Reset, then a=0x0F, b=0x11, start for 1 cycle -> busy=1 in cycles 1..9, done=1 only in cycle 9, product=0x00FF from cycle 9 on.
2. a=0xFF, b=0xFF -> product=0xFE01 (checks cout propagation every step). Then a=0x00, b=0x5A -> product=0x0000. Then a=0x80, b=0x02 -> 0x0100.
3. Start pulsed again in cycles 3 and 9 of a run with new a/b -> both ignored, result unchanged. Start held high continuously -> next run begins in the cycle after DONE (IDLE cycle), done period 10 cycles.
4. rst=1 in cycle 4 of a run with start also high -> busy=0 and product=0x0000 next cycle, no done pulse. A fresh start afterwards computes 0x0C*0x0D=0x009C correctly.
5. product stability: after 0x12*0x34=0x03A8, start 0x02*0x03 -> product reads 0x03A8 through RUN, changes to 0x0006 exactly with done.
6. Randomized: 181 seed-driven a/b pairs, each checked against (a*b) when done is high. Also run at WIDTH=4 exhaustively (256 pairs).
